bit3_hi_stage: RTL

Upper-digit companion to the 3-bit up/down counter (`bit3`). It sits directly downstream of `bit3`, consumes its carry/borrow (`cout`) and shares its `count`/`inc` controls. Together they form a synchronous 3+WIDTH-bit up/down counter. The block adds a sticky overflow/underflow monitor with a small state machine and an optional saturating stop.

---
 rtl/bit3_hi_stage.sv | 116 +++++++++++
 1 files changed

// File: rtl/bit3_hi_stage.sv
//------------------------------------------------------------------------------
// Module   : bit3_hi_stage
// Purpose  : Upper WIDTH-bit stage cascaded from bit3, with sticky overflow FSM.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bit3_hi_stage #(
  parameter int WIDTH   = 3,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             set_i,
  input  logic             count_i,
  input  logic             inc_i,
  input  logic             cin_i,
  input  logic [2:0]       q_lo_i,
  input  logic             clr_ovf_i,
  output logic [WIDTH-1:0] q_hi_o,
  output logic [WIDTH+2:0] q_all_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             ovf_up_o,
  output logic             stall_o,
  output logic             busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_OVF  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_hi_q, q_hi_d;
  logic             ovf_q, ovf_d;
  logic             ovf_up_q, ovf_up_d;

  logic             tc_hi;
  logic             stall;
  logic             step;
  logic             cout;

  assign tc_hi = inc_i ? (&q_hi_q) : ~(|q_hi_q);
  assign stall = (state_q == S_OVF) && (WRAP_EN == 1'b0);
  assign step  = count_i & cin_i & ~stall;
  assign cout  = step & tc_hi;

  always_comb begin
    q_hi_d = q_hi_q;
    if (step) begin
      if (inc_i) q_hi_d = q_hi_q + WIDTH'(1);
      else       q_hi_d = q_hi_q - WIDTH'(1);
    end
  end

  // A wrap seen from IDLE (e.g. counting down from zero) is still a wrap.
  always_comb begin
    state_d  = state_q;
    ovf_d    = ovf_q;
    ovf_up_d = ovf_up_q;
    case (state_q)
      S_IDLE: begin
        if (cout) begin
          state_d  = S_OVF;
          ovf_d    = 1'b1;
          ovf_up_d = inc_i;
        end else if (count_i) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cout) begin
          state_d  = S_OVF;
          ovf_d    = 1'b1;
          ovf_up_d = inc_i;
        end
      end
      S_OVF: begin
        if (cout) begin
          // A fresh wrap colliding with a clear re-arms the direction.
          if (clr_ovf_i) ovf_up_d = inc_i;
        end else if (clr_ovf_i) begin
          ovf_d   = 1'b0;
          state_d = count_i ? S_RUN : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (set_i) begin
      state_q  <= S_IDLE;
      q_hi_q   <= '0;
      ovf_q    <= 1'b0;
      ovf_up_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_hi_q   <= q_hi_d;
      ovf_q    <= ovf_d;
      ovf_up_q <= ovf_up_d;
    end
  end

  assign q_hi_o   = q_hi_q;
  assign q_all_o  = {q_hi_q, q_lo_i};
  assign cout_o   = cout;
  assign ovf_o    = ovf_q;
  assign ovf_up_o = ovf_up_q;
  assign stall_o  = stall;
  assign busy_o   = (state_q == S_RUN) || (state_q == S_OVF);

endmodule

`default_nettype wire
